// File: rtl/stable_code_encoder_pkg.sv
// stable_code_encoder_pkg
//   Shared types and constants for the stable_code_encoder slice.
//   state_e      : controller state encoding (IDLE / SETTLE / PRESENT)
//   CHANGE_CNT_W : width of the optional commit counter
package stable_code_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam int CHANGE_CNT_W = 8;

endpackage

// File: rtl/code_settle_cnt.sv
// code_settle_cnt
//   Holds the candidate code and its stability run counter.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     load       : capture code as new candidate, run count = 1
//     clear      : run count = 0 (candidate kept)
//     inc        : run count + 1
//     code       : current mapped input code
//     cand       : held candidate code
//     match      : code equals candidate
//     stable     : candidate seen for the final required sample this edge
module code_settle_cnt #(
  parameter int OUT_W      = 2,
  parameter int STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             inc,
  input  logic [OUT_W-1:0] code,
  output logic [OUT_W-1:0] cand,
  output logic             match,
  output logic             stable
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (load) begin
      cand <= code;
      cnt  <= CNT_W'(1);
    end else if (clear) begin
      cnt  <= '0;
    end else if (inc) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign match  = (code == cand);
  // The edge that sees the candidate with cnt == STABLE_CYC-1 is the
  // STABLE_CYC-th consecutive matching sample, so it is the commit edge.
  assign stable = match && (cnt == CNT_W'(STABLE_CYC - 1));

endmodule

// File: rtl/stable_code_encoder.sv
// stable_code_encoder
//   Maps an IN_W-bit raw input to an OUT_W-bit code and commits a new code
//   only after it has been stable for STABLE_CYC enabled samples. Each
//   committed code is offered with a valid/ready handshake.
//   Ports:
//     clk         : rising-edge clock
//     rst_n       : async active-low reset
//     en          : sample enable (low freezes everything but the handshake)
//     in          : raw input
//     out_ready   : consumer accepts presented code
//     binary_out  : last committed code (registered)
//     out_valid   : committed code awaiting acceptance
//     settling    : high while a candidate is being qualified
//     change_cnt  : saturating commit count (only with
//                   STABLE_CODE_ENCODER_CHANGE_CNT_EN defined)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | output settled, watching for a code different from it
//   SETTLE  | qualifying a candidate code over consecutive samples
//   PRESENT | new code committed, holding out_valid until accepted
module stable_code_encoder
  import stable_code_encoder_pkg::*;
#(
  parameter int IN_W         = 2,
  parameter int OUT_W        = 2,
  parameter int DIRECT_N     = 2,
  parameter int DEFAULT_CODE = 2,
  parameter int STABLE_CYC   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [IN_W-1:0]         in,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        binary_out,
  output logic                    out_valid,
  output logic                    settling
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
  ,
  output logic [CHANGE_CNT_W-1:0] change_cnt
`endif
);

  if (DEFAULT_CODE >= 2**OUT_W) begin : g_chk_default
    $error("DEFAULT_CODE does not fit in OUT_W bits");
  end
  if (DIRECT_N > 2**OUT_W) begin : g_chk_direct
    $error("DIRECT_N exceeds the number of OUT_W codes");
  end
  if (STABLE_CYC < 1) begin : g_chk_stable
    $error("STABLE_CYC must be at least 1");
  end

  state_e           state, state_n;
  logic [OUT_W-1:0] code;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] bout_n;
  logic             valid_n;
  logic             load, clear, inc;
  logic             match, stable;
  logic [31:0]      in_ext;

  // Compare at full input width; the cast truncates or zero-extends as needed.
  assign in_ext = 32'(in);
  assign code   = (in_ext < 32'(DIRECT_N)) ? OUT_W'(in) : OUT_W'(DEFAULT_CODE);

  code_settle_cnt #(
    .OUT_W      (OUT_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .clear  (clear),
    .inc    (inc),
    .code   (code),
    .cand   (cand),
    .match  (match),
    .stable (stable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      binary_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      binary_out <= bout_n;
      out_valid  <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    bout_n  = binary_out;
    valid_n = out_valid;
    load    = 1'b0;
    clear   = 1'b0;
    inc     = 1'b0;
    case (state)
      IDLE: begin
        if (en && (code != binary_out)) begin
          if (STABLE_CYC == 1) begin
            bout_n  = code;
            valid_n = 1'b1;
            state_n = PRESENT;
          end else begin
            load    = 1'b1;
            state_n = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (en) begin
          if (!match) begin
            if (code == binary_out) begin
              // Input went back to the committed code: nothing to change.
              clear   = 1'b1;
              state_n = IDLE;
            end else begin
              load = 1'b1;
            end
          end else if (stable) begin
            bout_n  = cand;
            valid_n = 1'b1;
            clear   = 1'b1;
            state_n = PRESENT;
          end else begin
            inc = 1'b1;
          end
        end
      end
      PRESENT: begin
        // Handshake completes regardless of en; input is not sampled here.
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign settling = (state == SETTLE);

`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
  logic commit;

  assign commit = (state != PRESENT) && (state_n == PRESENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt <= '0;
    end else if (commit && (change_cnt != '1)) begin
      change_cnt <= change_cnt + CHANGE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stable_code_encoder.sv
// tb_stable_code_encoder
//   Directed steps followed by a randomized phase, all checked against a
//   behavioural model of the commit rules (pending run length + candidate).
module tb_stable_code_encoder;

  localparam int IN_W         = 2;
  localparam int OUT_W        = 2;
  localparam int DIRECT_N     = 2;
  localparam int DEFAULT_CODE = 2;
  localparam int STABLE_CYC   = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [IN_W-1:0]  in_v;
  logic             out_ready;
  logic [OUT_W-1:0] binary_out;
  logic             out_valid;
  logic             settling;
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
  logic [7:0]       change_cnt;
`endif

  int n_checks;
  int n_errors;

  // model: committed code, valid flag, pending run length (0 = none), candidate, commits
  int m_out, m_valid, m_run, m_cand, m_chg;

  stable_code_encoder #(
    .IN_W         (IN_W),
    .OUT_W        (OUT_W),
    .DIRECT_N     (DIRECT_N),
    .DEFAULT_CODE (DEFAULT_CODE),
    .STABLE_CYC   (STABLE_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in         (in_v),
    .out_ready  (out_ready),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .settling   (settling)
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
    ,
    .change_cnt (change_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int map_code(int v);
    if (v < DIRECT_N) return v % (1 << OUT_W);
    return DEFAULT_CODE;
  endfunction

  task automatic model_reset();
    m_out = 0; m_valid = 0; m_run = 0; m_cand = 0; m_chg = 0;
  endtask

  task automatic model_edge();
    int c;
    if (m_valid != 0) begin
      if (out_ready) m_valid = 0;
    end else if (en) begin
      c = map_code(int'(in_v));
      if (m_run == 0) begin
        if (c != m_out) begin
          m_cand = c;
          m_run  = 1;
        end
      end else if (c != m_cand) begin
        if (c == m_out) m_run = 0;
        else begin
          m_cand = c;
          m_run  = 1;
        end
      end else begin
        m_run++;
      end
      if (m_run == STABLE_CYC) begin
        m_out   = m_cand;
        m_valid = 1;
        m_run   = 0;
        if (m_chg < 255) m_chg++;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".binary_out"}, 32'(binary_out), 32'(m_out));
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
    check({tag, ".settling"},   32'(settling),   32'(m_run > 0));
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
    check({tag, ".change_cnt"}, 32'(change_cnt), 32'(m_chg));
`endif
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    int hold;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    in_v      = '0;
    out_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset.binary_out", 32'(binary_out), 32'd0);
    check("reset.out_valid",  32'(out_valid),  32'd0);
    check("reset.settling",   32'(settling),   32'd0);
    rst_n = 1'b1;

    // First commit: 01 held, commit on the 4th sampling edge.
    en = 1'b1; in_v = 2'b01;
    repeat (3) begin
      tick("settle01");
      check("settle01.settling_hi", 32'(settling), 32'd1);
      check("settle01.out_low", 32'(binary_out), 32'd0);
    end
    tick("commit01");
    check("commit01.binary_out", 32'(binary_out), 32'd1);
    check("commit01.out_valid", 32'(out_valid), 32'd1);

    // PRESENT holds while not accepted, input changes ignored.
    in_v = 2'b00;
    repeat (10) begin
      tick("hold_present");
      check("hold_present.out", 32'(binary_out), 32'd1);
    end
    out_ready = 1'b1;
    tick("accept01");
    check("accept01.valid_low", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    repeat (3) tick("settle00");
    tick("commit00");
    check("commit00.binary_out", 32'(binary_out), 32'd0);
    check("commit00.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick("accept00");
    out_ready = 1'b0;

    // Unmapped inputs go to DEFAULT_CODE; a second unmapped value is no change.
    in_v = 2'b11;
    repeat (4) tick("settle11");
    check("commit11.binary_out", 32'(binary_out), 32'd2);
    out_ready = 1'b1;
    tick("accept11");
    out_ready = 1'b0;
    in_v = 2'b10;
    repeat (6) begin
      tick("same_default");
      check("same_default.no_valid", 32'(out_valid), 32'd0);
    end

    // Abort: input returns to the committed code mid-settle.
    in_v = 2'b01;
    repeat (2) tick("abort_pre");
    in_v = 2'b10;
    tick("abort");
    check("abort.settling_low", 32'(settling), 32'd0);
    repeat (5) begin
      tick("abort_post");
      check("abort_post.no_valid", 32'(out_valid), 32'd0);
    end

    // Freeze with en low after three samples; commit one edge after resume.
    in_v = 2'b01;
    repeat (3) tick("freeze_pre");
    en = 1'b0;
    repeat (3) begin
      tick("freeze");
      check("freeze.settling_hi", 32'(settling), 32'd1);
    end
    en = 1'b1;
    tick("freeze_resume");
    check("freeze_resume.binary_out", 32'(binary_out), 32'd1);
    check("freeze_resume.out_valid", 32'(out_valid), 32'd1);

    // Handshake still completes with en low.
    en = 1'b0; out_ready = 1'b1;
    tick("accept_en_low");
    check("accept_en_low.valid_low", 32'(out_valid), 32'd0);
    en = 1'b1; out_ready = 1'b0;

    // Reset mid-settle discards the pending code immediately.
    in_v = 2'b00;
    repeat (2) tick("rst_pre");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.binary_out", 32'(binary_out), 32'd0);
    check("rst_mid.out_valid",  32'(out_valid),  32'd0);
    check("rst_mid.settling",   32'(settling),   32'd0);
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
    check("rst_mid.change_cnt", 32'(change_cnt), 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    in_v = 2'b01;
    repeat (4) tick("post_rst");
    check("post_rst.binary_out", 32'(binary_out), 32'd1);
`ifdef STABLE_CODE_ENCODER_CHANGE_CNT_EN
    check("post_rst.change_cnt", 32'(change_cnt), 32'd1);
`endif

    // Randomized phase: held input runs of random length.
    for (int i = 0; i < 150; i++) begin
      in_v = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      hold = $urandom_range(1, 7);
      for (int j = 0; j < hold; j++) begin
        en        = ($urandom_range(0, 7) != 0);
        out_ready = ($urandom_range(0, 3) == 0);
        tick("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
